// File: rtl/mem_arbiter_mb.sv
// N-channel arbiter onto one byte-wide synchronous RAM.
// Serves 1/2/4-byte little-endian reads and writes, one byte per cycle.
module mem_arbiter_mb #(
  parameter int NCH        = 2,
  parameter int ADDR_W     = 32,
  parameter int RAM_ADDR_W = 17,
  parameter int DAT_W      = 8,
  parameter int RR_MODE    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NCH-1:0]        iReq,
  input  logic [NCH-1:0]        iRw,
  input  logic [2*NCH-1:0]      iLen,
  input  logic [ADDR_W*NCH-1:0] iAdd,
  input  logic [32*NCH-1:0]     iDat,
  output logic [NCH-1:0]        oDone,
  output logic [31:0]           oRData,
  output logic                  oBusy,
  output logic [NCH-1:0]        oGrant,
  output logic                  oRAM_Rw,
  output logic [RAM_ADDR_W-1:0] oRAM_Add,
  output logic [DAT_W-1:0]      oRAM_Dat,
  input  logic [DAT_W-1:0]      iRAM_Dat
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TAIL,
    DONE
  } st_t;

  st_t                   st_q, st_d;
  logic                  rw_q, rw_d;
  logic [2:0]            nb_q, nb_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0] add_q, add_d;
  logic [31:0]           dat_q, dat_d;
  logic [CW-1:0]         rr_q, rr_d;
  logic [NCH-1:0]        done_q, done_d;
  logic [NCH-1:0]        gnt_q, gnt_d;
  logic                  busy_q, busy_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ram_rw_q, ram_rw_d;
  logic [RAM_ADDR_W-1:0] ram_add_q, ram_add_d;
  logic [DAT_W-1:0]      ram_dat_q, ram_dat_d;

  logic [NCH-1:0] elig;
  logic           found;
  logic [CW-1:0]  win;
  logic [1:0]     xidx;
  logic [1:0]     tidx;

  assign oDone    = done_q;
  assign oRData   = rdata_q;
  assign oBusy    = busy_q;
  assign oGrant   = gnt_q;
  assign oRAM_Rw  = ram_rw_q;
  assign oRAM_Add = ram_add_q;
  assign oRAM_Dat = ram_dat_q;

  // A channel whose done pulse is showing sits out one arbitration.
  always_comb begin
    elig  = iReq & ~done_q;
    found = 1'b0;
    win   = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NCH; k++) begin
        if (!found && elig[(int'(rr_q) + k) % NCH]) begin
          found = 1'b1;
          win   = CW'((int'(rr_q) + k) % NCH);
        end
      end
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (elig[j]) begin
          found = 1'b1;
          win   = CW'(j);
        end
      end
    end
  end

  always_comb begin
    st_d      = st_q;
    rw_d      = rw_q;
    nb_d      = nb_q;
    cnt_d     = cnt_q;
    add_d     = add_q;
    dat_d     = dat_q;
    rr_d      = rr_q;
    done_d    = '0;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    rdata_d   = rdata_q;
    ram_rw_d  = 1'b1;
    ram_add_d = ram_add_q;
    ram_dat_d = ram_dat_q;
    xidx      = cnt_q[1:0] - 2'd2;
    tidx      = nb_q[1:0] - 2'd1;
    unique case (st_q)
      IDLE, DONE: begin
        st_d   = IDLE;
        gnt_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          st_d   = XFER;
          gnt_d  = {{(NCH-1){1'b0}}, 1'b1} << win;
          busy_d = 1'b1;
          rw_d   = iRw[win];
          add_d  = iAdd[ADDR_W*int'(win) +: RAM_ADDR_W];
          dat_d  = iDat[32*int'(win) +: 32];
          cnt_d  = '0;
          case (iLen[2*int'(win) +: 2])
            2'd0:    nb_d = 3'd1;
            2'd1:    nb_d = 3'd2;
            default: nb_d = 3'd4;
          endcase
          if (!iRw[win]) rdata_d = '0;
          if (RR_MODE != 0) rr_d = win;
        end
      end
      XFER: begin
        // Read data lags its address by two edges.
        if (!rw_q && cnt_q >= 3'd2)
          rdata_d[DAT_W*int'(xidx) +: DAT_W] = iRAM_Dat;
        if (cnt_q == nb_q) begin
          if (rw_q) begin
            st_d   = DONE;
            done_d = gnt_q;
            gnt_d  = '0;
            busy_d = 1'b0;
          end else begin
            st_d = TAIL;
          end
        end else begin
          ram_add_d = add_q + RAM_ADDR_W'(cnt_q);
          ram_rw_d  = ~rw_q;
          if (rw_q)
            ram_dat_d = dat_q[DAT_W*int'(cnt_q[1:0]) +: DAT_W];
          cnt_d = cnt_q + 3'd1;
        end
      end
      TAIL: begin
        rdata_d[DAT_W*int'(tidx) +: DAT_W] = iRAM_Dat;
        st_d   = DONE;
        done_d = gnt_q;
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q      <= IDLE;
      rw_q      <= 1'b0;
      nb_q      <= 3'd1;
      cnt_q     <= '0;
      add_q     <= '0;
      dat_q     <= '0;
      rr_q      <= CW'(NCH - 1);
      done_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      rdata_q   <= '0;
      ram_rw_q  <= 1'b1;
      ram_add_q <= '0;
      ram_dat_q <= '0;
    end else if (en) begin
      st_q      <= st_d;
      rw_q      <= rw_d;
      nb_q      <= nb_d;
      cnt_q     <= cnt_d;
      add_q     <= add_d;
      dat_q     <= dat_d;
      rr_q      <= rr_d;
      done_q    <= done_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      rdata_q   <= rdata_d;
      ram_rw_q  <= ram_rw_d;
      ram_add_q <= ram_add_d;
      ram_dat_q <= ram_dat_d;
    end else begin
      // Stalled: keep the RAM from repeating the current write byte.
      ram_rw_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_mb.sv
// Directed bench for mem_arbiter_mb with a byte RAM model.
// Fixed-priority and round-robin instances share one stimulus.
module tb_mem_arbiter_mb;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [1:0]  iReq, iRw;
  logic [3:0]  iLen;
  logic [63:0] iAdd, iDat;
  logic [1:0]  oDone, oGrant;
  logic [31:0] oRData;
  logic        oBusy, oRAM_Rw;
  logic [16:0] oRAM_Add;
  logic [7:0]  oRAM_Dat, ram_q;
  logic [1:0]  r_Done, r_Grant;
  logic [31:0] r_RData;
  logic        r_Busy, r_Rw;
  logic [16:0] r_Add;
  logic [7:0]  r_Dat;

  bit [7:0] mem [0:131071];
  int       wcnt [0:15];
  int       nchk = 0;
  int       nerr = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_q <= mem[oRAM_Add];
    if (!oRAM_Rw) begin
      mem[oRAM_Add] <= oRAM_Dat;
      if (oRAM_Add[16:4] == 13'h040)
        wcnt[oRAM_Add[3:0]] <= wcnt[oRAM_Add[3:0]] + 1;
    end
  end

  mem_arbiter_mb #(.NCH(2), .RR_MODE(0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .iReq(iReq), .iRw(iRw), .iLen(iLen),
    .iAdd(iAdd), .iDat(iDat),
    .oDone(oDone), .oRData(oRData), .oBusy(oBusy),
    .oGrant(oGrant), .oRAM_Rw(oRAM_Rw),
    .oRAM_Add(oRAM_Add), .oRAM_Dat(oRAM_Dat),
    .iRAM_Dat(ram_q)
  );

  mem_arbiter_mb #(.NCH(2), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .en(en),
    .iReq(iReq), .iRw(iRw), .iLen(iLen),
    .iAdd(iAdd), .iDat(iDat),
    .oDone(r_Done), .oRData(r_RData), .oBusy(r_Busy),
    .oGrant(r_Grant), .oRAM_Rw(r_Rw),
    .oRAM_Add(r_Add), .oRAM_Dat(r_Dat),
    .iRAM_Dat(ram_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setch(input int c, input logic rw, input logic [1:0] len,
                       input logic [31:0] a, input logic [31:0] d);
    iRw[c]          = rw;
    iLen[2*c +: 2]  = len;
    iAdd[32*c +: 32] = a;
    iDat[32*c +: 32] = d;
  endtask

  function automatic logic [31:0] rd32(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  initial begin
    rst = 1'b0; en = 1'b1; iReq = '0; iRw = '0;
    iLen = '0; iAdd = '0; iDat = '0;
    for (int i = 0; i < 16; i++) wcnt[i] = 0;
    tick(); tick();
    chk("rst_done",  32'(oDone),    32'h0);
    chk("rst_rdata", oRData,        32'h0);
    chk("rst_busy",  32'(oBusy),    32'h0);
    chk("rst_grant", 32'(oGrant),   32'h0);
    chk("rst_rw",    32'(oRAM_Rw),  32'h1);
    chk("rst_add",   32'(oRAM_Add), 32'h0);
    chk("rst_dat",   32'(oRAM_Dat), 32'h0);
    rst = 1'b1;

    // reset in the middle of a 4-byte write
    setch(1, 1'b1, 2'd3, 32'h200, 32'h11223344);
    iReq = 2'b10;
    tick();
    chk("mr_grant", 32'(oGrant), 32'h2);
    iReq = 2'b00;
    tick();
    chk("mr_c1_add", 32'(oRAM_Add), 32'h200);
    chk("mr_c1_rw",  32'(oRAM_Rw),  32'h0);
    tick();
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    chk("mr_done",  32'(oDone),    32'h0);
    chk("mr_busy",  32'(oBusy),    32'h0);
    chk("mr_grant0", 32'(oGrant),  32'h0);
    chk("mr_rw",    32'(oRAM_Rw),  32'h1);
    chk("mr_add",   32'(oRAM_Add), 32'h0);
    chk("mr_dat",   32'(oRAM_Dat), 32'h0);
    tick(); tick(); tick(); tick();
    chk("mr_done_late", 32'(oDone), 32'h0);
    chk("mr_m201", 32'(mem[17'h201]), 32'h33);
    chk("mr_m202", 32'(mem[17'h202]), 32'h00);
    chk("mr_m203", 32'(mem[17'h203]), 32'h00);

    // ch1 4-byte write, fields scrambled after grant
    setch(1, 1'b1, 2'd3, 32'h100, 32'hDEADBEEF);
    iReq = 2'b10;
    tick();
    chk("w_grant", 32'(oGrant),  32'h2);
    chk("w_busy",  32'(oBusy),   32'h1);
    chk("w_c0_rw", 32'(oRAM_Rw), 32'h1);
    iReq = 2'b00;
    setch(1, 1'b0, 2'd0, 32'h999, 32'h0);
    tick();
    chk("w_c1", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h100, 8'hEF});
    tick();
    chk("w_c2", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h101, 8'hBE});
    tick();
    chk("w_c3", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h102, 8'hAD});
    tick();
    chk("w_c4", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h103, 8'hDE});
    chk("w_c4_done", 32'(oDone), 32'h0);
    tick();
    chk("w_c5_done",  32'(oDone),   32'h2);
    chk("w_c5_grant", 32'(oGrant),  32'h0);
    chk("w_c5_busy",  32'(oBusy),   32'h0);
    chk("w_c5_rw",    32'(oRAM_Rw), 32'h1);
    tick();
    chk("w_c6_done", 32'(oDone),    32'h0);
    chk("w_c6_add",  32'(oRAM_Add), 32'h103);
    chk("w_mem",     rd32(32'h100), 32'hDEADBEEF);

    // ch0 2-byte reads
    setch(0, 1'b0, 2'd1, 32'h101, 32'h0);
    iReq = 2'b01;
    tick();
    chk("r1_grant", 32'(oGrant), 32'h1);
    iReq = 2'b00;
    tick();
    chk("r1_c1", {oRAM_Rw, oRAM_Add}, {1'b1, 17'h101});
    tick();
    chk("r1_c2", {oRAM_Rw, oRAM_Add}, {1'b1, 17'h102});
    tick();
    chk("r1_c3_done", 32'(oDone), 32'h0);
    tick();
    chk("r1_c4_done", 32'(oDone), 32'h1);
    chk("r1_data",    oRData,     32'h0000ADBE);
    tick();
    setch(0, 1'b0, 2'd1, 32'h102, 32'h0);
    iReq = 2'b01;
    tick();
    chk("r2_clear", oRData, 32'h0);
    iReq = 2'b00;
    tick(); tick(); tick(); tick();
    chk("r2_c4_done", 32'(oDone), 32'h1);
    chk("r2_data",    oRData,     32'h0000DEAD);
    tick();

    // fixed priority contest: ch1 then ch0 back to back
    setch(1, 1'b1, 2'd0, 32'h300, 32'h5A);
    setch(0, 1'b0, 2'd0, 32'h100, 32'h0);
    iReq = 2'b11;
    tick();
    chk("fp_first", 32'(oGrant), 32'h2);
    iReq = 2'b01;
    tick();
    chk("fp_c1", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h300, 8'h5A});
    tick();
    chk("fp_c2_done", 32'(oDone), 32'h2);
    tick();
    chk("fp_second", 32'(oGrant), 32'h1);
    chk("fp_busy",   32'(oBusy),  32'h1);
    iReq = 2'b00;
    tick(); tick(); tick();
    chk("fp_c6_done", 32'(oDone), 32'h1);
    chk("fp_data",    oRData,     32'h000000EF);
    tick();

    // 4-byte read wrapping the RAM address space
    mem[17'h1FFFE] = 8'h11; mem[17'h1FFFF] = 8'h22;
    mem[17'h00000] = 8'h33; mem[17'h00001] = 8'h44;
    setch(0, 1'b0, 2'd3, 32'h0001FFFE, 32'h0);
    iReq = 2'b01;
    tick();
    iReq = 2'b00;
    tick();
    chk("wr_a0", 32'(oRAM_Add), 32'h1FFFE);
    tick();
    chk("wr_a1", 32'(oRAM_Add), 32'h1FFFF);
    tick();
    chk("wr_a2", 32'(oRAM_Add), 32'h00000);
    tick();
    chk("wr_a3", 32'(oRAM_Add), 32'h00001);
    tick();
    chk("wr_c5_done", 32'(oDone), 32'h0);
    tick();
    chk("wr_c6_done", 32'(oDone), 32'h1);
    chk("wr_data",    oRData,     32'h44332211);
    tick();

    // 3-cycle stall in a 4-byte write
    setch(1, 1'b1, 2'd3, 32'h400, 32'hCAFEF00D);
    iReq = 2'b10;
    tick();
    iReq = 2'b00;
    tick();
    chk("st_c1", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h400, 8'h0D});
    tick();
    chk("st_c2", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h401, 8'hF0});
    en = 1'b0;
    tick();
    chk("st_c3_rw", 32'(oRAM_Rw), 32'h1);
    tick();
    chk("st_c4_rw", 32'(oRAM_Rw), 32'h1);
    tick();
    chk("st_c5_rw",  32'(oRAM_Rw),  32'h1);
    chk("st_c5_add", 32'(oRAM_Add), 32'h401);
    en = 1'b1;
    tick();
    chk("st_c6", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h402, 8'hFE});
    tick();
    chk("st_c7", {oRAM_Rw, 6'h0, oRAM_Add, oRAM_Dat}, {1'b0, 6'h0, 17'h403, 8'hCA});
    chk("st_c7_done", 32'(oDone), 32'h0);
    tick();
    chk("st_c8_done", 32'(oDone), 32'h2);
    tick();
    chk("st_mem", rd32(32'h400), 32'hCAFEF00D);
    chk("st_wc", {wcnt[0][7:0], wcnt[1][7:0], wcnt[2][7:0], wcnt[3][7:0]},
        32'h01010101);

    // both channels held high: fixed vs round-robin grant order
    rst = 1'b0;
    tick(); tick();
    setch(0, 1'b0, 2'd0, 32'h10, 32'h0);
    setch(1, 1'b0, 2'd0, 32'h20, 32'h0);
    iReq = 2'b11;
    rst = 1'b1;
    tick();
    chk("rr_g0", 32'(r_Grant), 32'h1);
    chk("fp_g0", 32'(oGrant),  32'h2);
    tick(); tick(); tick(); tick();
    chk("rr_g1", 32'(r_Grant), 32'h2);
    chk("fp_g1", 32'(oGrant),  32'h1);
    tick(); tick(); tick(); tick();
    chk("rr_g2", 32'(r_Grant), 32'h1);
    chk("fp_g2", 32'(oGrant),  32'h2);
    tick(); tick(); tick(); tick();
    chk("rr_g3", 32'(r_Grant), 32'h2);
    chk("fp_g3", 32'(oGrant),  32'h1);
    iReq = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    chk("end_busy", {30'h0, oBusy, r_Busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
